// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave frame front-end.
package spi_slave_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        WAIT_TX,
        TX,
        DONE
    } state_t;

endpackage

// File: rtl/spi_shifter.sv
// Generic W-bit shift register: parallel load, MSB-first serial shift-in, MSB serial out.
module spi_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         din,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] par_out,
    output logic         ser_out
);

    logic [W-1:0] r_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= par_in;
        end else if (shift) begin
            r_q <= {r_q[W-2:0], din};
        end
    end

    assign par_out = r_q;
    assign ser_out = r_q[W-1];

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave frame front-end: receives {cmd, payload} frames and serves RD_DATA replies on MISO.
// Optional even parity on both directions when SPI_SLAVE_PARITY_EN is defined.
module spi_slave_frame
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = DATA_W + CMD_W;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int RX_LEN = FRAME_W + PAR_W;
    localparam int TX_LEN = DATA_W + PAR_W;
    localparam int CNT_W  = $clog2(RX_LEN + 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_to_cnt, w_to_nxt;
    logic               r_rd_pend, w_rd_pend_nxt;
    logic               r_rx_valid, w_rx_valid_nxt;
    logic               r_frame_err, w_frame_err_nxt;
    logic [FRAME_W-1:0] r_rx_data, w_rx_data_nxt;

    logic               w_rx_shift, w_tx_load, w_tx_shift;
    logic [FRAME_W-1:0] w_rx_q, w_frame;
    logic [DATA_W-1:0]  w_tx_q;
    logic               w_rx_ser, w_tx_ser, w_par_ok, w_unused;
    logic [CMD_W-1:0]   w_cmd;

    spi_shifter #(.W(FRAME_W)) u_rx_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .shift   (w_rx_shift),
        .din     (MOSI),
        .par_in  ({FRAME_W{1'b0}}),
        .par_out (w_rx_q),
        .ser_out (w_rx_ser)
    );

    spi_shifter #(.W(DATA_W)) u_tx_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tx_load),
        .shift   (w_tx_shift),
        .din     (1'b0),
        .par_in  (tx_data),
        .par_out (w_tx_q),
        .ser_out (w_tx_ser)
    );

    // The frame decision is taken on the edge that samples the final bit, so the last bit comes straight from MOSI.
`ifdef SPI_SLAVE_PARITY_EN
    logic r_tx_par;

    assign w_frame  = w_rx_q;
    assign w_par_ok = ~^{w_rx_q, MOSI};
    assign w_unused = &{1'b0, w_rx_ser, w_tx_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_par <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_par <= ^tx_data;
        end
    end

    assign MISO = (r_state != TX)             ? 1'b0     :
                  (r_cnt == CNT_W'(DATA_W))   ? r_tx_par : w_tx_ser;
`else
    assign w_frame  = {w_rx_q[FRAME_W-2:0], MOSI};
    assign w_par_ok = 1'b1;
    assign w_unused = &{1'b0, w_rx_ser, w_rx_q[FRAME_W-1], w_tx_q};
    assign MISO     = (r_state == TX) ? w_tx_ser : 1'b0;
`endif

    assign w_cmd = w_frame[FRAME_W-1 -: CMD_W];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_to_nxt        = r_to_cnt;
        w_rd_pend_nxt   = r_rd_pend;
        w_rx_valid_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_rx_data_nxt   = r_rx_data;
        w_rx_shift      = 1'b0;
        w_tx_load       = 1'b0;
        w_tx_shift      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!ss_n) begin
                    w_rx_shift  = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = RX;
                end
            end
            RX: begin
                if (ss_n) begin
                    w_cnt_nxt       = '0;
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (r_cnt == CNT_W'(RX_LEN - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                    if (!w_par_ok) begin
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        case (w_cmd)
                            CMD_RD_ADDR: begin
                                w_rd_pend_nxt  = 1'b1;
                                w_rx_valid_nxt = 1'b1;
                                w_rx_data_nxt  = w_frame;
                            end
                            CMD_RD_DATA: begin
                                if (r_rd_pend) begin
                                    w_rd_pend_nxt  = 1'b0;
                                    w_rx_valid_nxt = 1'b1;
                                    w_rx_data_nxt  = w_frame;
                                    w_to_nxt       = '0;
                                    w_state_nxt    = WAIT_TX;
                                end else begin
                                    w_frame_err_nxt = 1'b1;
                                end
                            end
                            default: begin
                                w_rx_valid_nxt = 1'b1;
                                w_rx_data_nxt  = w_frame;
                            end
                        endcase
                    end
                end else begin
                    w_rx_shift = 1'b1;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            WAIT_TX: begin
                if (ss_n) begin
                    w_cnt_nxt       = '0;
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (tx_valid) begin
                    w_tx_load   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TX;
                end else if (r_to_cnt == 8'(TX_TIMEOUT - 1)) begin
                    w_to_nxt        = '0;
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_to_nxt = r_to_cnt + 8'd1;
                end
            end
            TX: begin
                if (ss_n) begin
                    w_cnt_nxt       = '0;
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (r_cnt == CNT_W'(TX_LEN - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_tx_shift = 1'b1;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (ss_n) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_rd_pend   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to_cnt    <= w_to_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_rx_data   <= w_rx_data_nxt;
        end
    end

    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule
